// File: rtl/pc_unit_v2_if.sv
// Decode/fetch-side bundle for the program counter unit.
// Inputs are driven by the master. The PC and return-stack status come back from the slave.
interface pc_unit_v2_if #(
   parameter int ADDR_W    = 16,
   parameter int OFF_W     = 9,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic              i_stall;
   logic [2:0]        i_pc_op;
   logic [2:0]        i_cond;
   logic [OFF_W-1:0]  i_imm;
   logic [2:0]        i_flag;
   logic [ADDR_W-1:0] i_reg_addr;
   logic [ADDR_W-1:0] o_pc;
   logic [ADDR_W-1:0] o_pc_plus2;
   logic              o_taken;
   logic              o_halted;
   logic [CNT_W-1:0]  o_ras_count;
   logic              o_ras_empty;
   logic              o_ras_full;
   logic              o_ras_ovf;
   logic              o_ras_unf;

   modport master (
      output i_stall, i_pc_op, i_cond, i_imm, i_flag, i_reg_addr,
      input  o_pc, o_pc_plus2, o_taken, o_halted, o_ras_count,
             o_ras_empty, o_ras_full, o_ras_ovf, o_ras_unf
   );

   modport slave (
      input  i_stall, i_pc_op, i_cond, i_imm, i_flag, i_reg_addr,
      output o_pc, o_pc_plus2, o_taken, o_halted, o_ras_count,
             o_ras_empty, o_ras_full, o_ras_ovf, o_ras_unf
   );
endinterface

// File: rtl/pc_unit_v2.sv
// Program counter with conditional branch/jump, call/return through a circular
// return-address stack, stall and sticky halt.
//   state    | meaning
//   S_RUN    | PC advances per pc_op unless stalled
//   S_HALTED | PC frozen on the HALT address until reset
module pc_unit_v2 #(
   parameter int                 ADDR_W    = 16,
   parameter int                 OFF_W     = 9,
   parameter int                 RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   pc_unit_v2_if.slave   bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] OP_BR    = 3'd1;
   localparam logic [2:0] OP_JR    = 3'd2;
   localparam logic [2:0] OP_CALL  = 3'd3;
   localparam logic [2:0] OP_CALLR = 3'd4;
   localparam logic [2:0] OP_RET   = 3'd5;
   localparam logic [2:0] OP_HALT  = 3'd6;

   typedef enum logic {S_RUN, S_HALTED} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_plus2, w_br_tgt, w_sext, w_ras_top;
   logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0]  r_wr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf, r_unf;
   logic              w_cond_ok, w_push, w_pop, w_set_unf, w_taken;
   logic              w_n, w_v, w_z;

   assign {w_n, w_v, w_z} = bus.i_flag;
   assign w_pc_plus2 = r_pc + ADDR_W'(2);
   assign w_sext     = {{(ADDR_W-OFF_W){bus.i_imm[OFF_W-1]}}, bus.i_imm};
   assign w_br_tgt   = w_pc_plus2 + (w_sext << 1);
   // r_wr is the next free slot, so the newest entry sits one below it
   assign w_ras_top  = r_ras[r_wr - PTR_W'(1)];

   always_comb begin
      w_cond_ok = 1'b1;
      case (bus.i_cond)
         3'd0:    w_cond_ok = !w_z;
         3'd1:    w_cond_ok = w_z;
         3'd2:    w_cond_ok = !w_z && !w_n;
         3'd3:    w_cond_ok = w_n;
         3'd4:    w_cond_ok = w_z || !w_n;
         3'd5:    w_cond_ok = w_z || w_n;
         3'd6:    w_cond_ok = w_v;
         default: w_cond_ok = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_set_unf   = 1'b0;
      w_taken     = 1'b0;
      if (r_state == S_RUN) begin
         w_pc_nxt = w_pc_plus2;
         case (bus.i_pc_op)
            OP_BR: if (w_cond_ok) begin
               w_taken  = 1'b1;
               w_pc_nxt = w_br_tgt;
            end
            OP_JR: if (w_cond_ok) begin
               w_taken  = 1'b1;
               w_pc_nxt = bus.i_reg_addr;
            end
            OP_CALL: begin
               w_taken  = 1'b1;
               w_push   = 1'b1;
               w_pc_nxt = w_br_tgt;
            end
            OP_CALLR: begin
               w_taken  = 1'b1;
               w_push   = 1'b1;
               w_pc_nxt = bus.i_reg_addr;
            end
            OP_RET: if (r_cnt != '0) begin
               w_taken  = 1'b1;
               w_pop    = 1'b1;
               w_pc_nxt = w_ras_top;
            end else begin
               w_set_unf = 1'b1;
            end
            OP_HALT: begin
               w_pc_nxt    = r_pc;
               w_state_nxt = S_HALTED;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_RUN;
         r_pc    <= RESET_VEC;
         r_wr    <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (!bus.i_stall) begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_push) begin
            r_wr <= r_wr + PTR_W'(1);
            // a full stack drops its oldest entry, which is the slot being written
            if (r_cnt == CNT_W'(RAS_DEPTH)) r_ovf <= 1'b1;
            else                            r_cnt <= r_cnt + CNT_W'(1);
         end else if (w_pop) begin
            r_wr  <= r_wr - PTR_W'(1);
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_set_unf) r_unf <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && !bus.i_stall && w_push) r_ras[r_wr] <= w_pc_plus2;
   end

   assign bus.o_pc        = r_pc;
   assign bus.o_pc_plus2  = w_pc_plus2;
   assign bus.o_taken     = w_taken;
   assign bus.o_halted    = (r_state == S_HALTED);
   assign bus.o_ras_count = r_cnt;
   assign bus.o_ras_empty = (r_cnt == '0);
   assign bus.o_ras_full  = (r_cnt == CNT_W'(RAS_DEPTH));
   assign bus.o_ras_ovf   = r_ovf;
   assign bus.o_ras_unf   = r_unf;
endmodule

// File: tb/tb_pc_unit_v2.sv
// Bench for pc_unit_v2: directed scenarios plus random ops against a queue-based
// model of the PC and return-address stack.
module tb_pc_unit_v2;
   localparam int ADDR_W = 16;
   localparam int OFF_W  = 9;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pc_unit_v2_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH)) bus ();

   pc_unit_v2 #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   int m_pc;
   int m_q[$];
   bit m_halted, m_ovf, m_unf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond_true(input int c, input int f);
      bit n, v, z;
      n = f[2]; v = f[1]; z = f[0];
      case (c)
         0: return !z;
         1: return z;
         2: return !z && !n;
         3: return n;
         4: return z || !n;
         5: return z || n;
         6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic int sext(input int im);
      int s;
      s = im & 'h1FF;
      if (s >= 256) s = s - 512;
      return s;
   endfunction

   task automatic check_state();
      check("pc",        bus.o_pc,        m_pc);
      check("halted",    bus.o_halted,    m_halted);
      check("ras_count", bus.o_ras_count, m_q.size());
      check("ras_empty", bus.o_ras_empty, m_q.size() == 0);
      check("ras_full",  bus.o_ras_full,  m_q.size() == DEPTH);
      check("ras_ovf",   bus.o_ras_ovf,   m_ovf);
      check("ras_unf",   bus.o_ras_unf,   m_unf);
   endtask

   task automatic do_reset(input bit stl);
      @(negedge clk);
      rst = 1'b1;
      bus.i_stall = stl;
      bus.i_pc_op = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_pc = 0; m_q.delete(); m_halted = 0; m_ovf = 0; m_unf = 0;
      check_state();
   endtask

   task automatic step(input int op, input int cnd, input int im, input int flg,
                       input int ra, input bit stl);
      int npc, p2, tgt;
      bit tk, nhalt, nov, nun;
      int nq[$];
      @(negedge clk);
      bus.i_pc_op    = op[2:0];
      bus.i_cond     = cnd[2:0];
      bus.i_imm      = im[8:0];
      bus.i_flag     = flg[2:0];
      bus.i_reg_addr = ra[15:0];
      bus.i_stall    = stl;
      #1;
      p2  = (m_pc + 2) & 'hFFFF;
      tgt = (p2 + sext(im) * 2) & 'hFFFF;
      npc = p2; tk = 0; nhalt = m_halted; nov = m_ovf; nun = m_unf; nq = m_q;
      if (m_halted) npc = m_pc;
      else case (op)
         1: if (cond_true(cnd, flg)) begin tk = 1; npc = tgt; end
         2: if (cond_true(cnd, flg)) begin tk = 1; npc = ra & 'hFFFF; end
         3, 4: begin
            tk = 1;
            if (nq.size() == DEPTH) begin void'(nq.pop_front()); nov = 1; end
            nq.push_back(p2);
            npc = (op == 3) ? tgt : (ra & 'hFFFF);
         end
         5: if (nq.size() > 0) begin tk = 1; npc = nq.pop_back(); end
            else nun = 1;
         6: begin nhalt = 1; npc = m_pc; end
         default: ;
      endcase
      check("taken",    bus.o_taken,    tk);
      check("pc_plus2", bus.o_pc_plus2, p2);
      @(posedge clk);
      #1;
      if (!stl) begin
         m_pc = npc; m_q = nq; m_halted = nhalt; m_ovf = nov; m_unf = nun;
      end
      check_state();
   endtask

   task automatic jump_to(input int a);
      step(2, 7, 0, 0, a, 0);
   endtask

   initial begin
      bus.i_stall = 0; bus.i_pc_op = 0; bus.i_cond = 0; bus.i_imm = 0;
      bus.i_flag = 0; bus.i_reg_addr = 0;

      do_reset(0);
      check("tp_reset_pc", bus.o_pc, 16'h0000);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
      check("tp_seq_pc", bus.o_pc, 16'h0006);

      jump_to('h10);
      step(1, 1, 'h1FC, 'b001, 0, 0);
      check("tp_br_taken", bus.o_pc, 16'h000A);
      jump_to('h10);
      step(1, 1, 'h1FC, 'b000, 0, 0);
      check("tp_br_not", bus.o_pc, 16'h0012);

      jump_to('h20);
      step(3, 0, 'h010, 0, 0, 0);
      check("tp_call", bus.o_pc, 16'h0042);
      step(4, 0, 0, 0, 'h100, 0);
      check("tp_callr", bus.o_pc, 16'h0100);
      check("tp_callr_cnt", bus.o_ras_count, 2);
      step(5, 0, 0, 0, 0, 0);
      check("tp_ret1", bus.o_pc, 16'h0044);
      step(5, 0, 0, 0, 0, 0);
      check("tp_ret2", bus.o_pc, 16'h0022);
      step(5, 0, 0, 0, 0, 0);
      check("tp_ret3", bus.o_pc, 16'h0024);
      check("tp_unf", bus.o_ras_unf, 1'b1);

      do_reset(0);
      for (int i = 0; i < 5; i++) begin
         jump_to('h200 + 'h40 * i);
         step(3, 0, 'h8, 0, 0, 0);
      end
      check("tp_full", bus.o_ras_full, 1'b1);
      check("tp_ovf", bus.o_ras_ovf, 1'b1);
      for (int i = 4; i >= 1; i--) begin
         step(5, 0, 0, 0, 0, 0);
         check("tp_ras_lifo", bus.o_pc, 'h200 + 'h40 * i + 2);
      end
      step(5, 0, 0, 0, 0, 0);
      check("tp_ras_lost", bus.o_ras_unf, 1'b1);

      jump_to('h80);
      for (int i = 0; i < 3; i++) step(1, 7, 'h10, 0, 0, 1);
      check("tp_stall_pc", bus.o_pc, 16'h0080);
      step(1, 7, 'h10, 0, 0, 0);
      check("tp_stall_rel", bus.o_pc, 16'h00A2);
      jump_to('hFFFE);
      step(0, 0, 0, 0, 0, 0);
      check("tp_wrap", bus.o_pc, 16'h0000);

      do_reset(1);
      for (int i = 0; i < 400; i++) begin
         int op;
         op = $urandom_range(0, 6);
         if (op == 6) op = 7;
         step(op, $urandom_range(0, 7), $urandom_range(0, 511), $urandom_range(0, 7),
              $urandom_range(0, 65535), $urandom_range(0, 3) == 0);
      end

      jump_to('h30);
      step(6, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 511),
              $urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 1));
      check("tp_halt_pc", bus.o_pc, 16'h0030);
      check("tp_halted", bus.o_halted, 1'b1);
      do_reset(1);
      check("tp_rst_halt", bus.o_halted, 1'b0);
      step(0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
